// File: rtl/rtc_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter_pkg
//   Shared definitions for the RTC bus arbiter slice:
//   - bus-cycle state encoding (exported on the arbiter's debug state port)
//   - default address/data widths and phase length
//   - RTC register address map used by the control sequencer
//   - arbitration helper (round-robin between write and read paths)
// ---------------------------------------------------------------------------
package rtc_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_T_PHASE = 8;

    // One single-register bus cycle walks ADDR -> ADDR_HOLD -> DATA -> RECOVER
    // and returns to IDLE, where the next request is arbitrated.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_HOLD = 3'd2,
        ST_DATA      = 3'd3,
        ST_RECOVER   = 3'd4
    } state_e;

    // RTC register map (time/date/chrono block).
    localparam logic [7:0] RTC_REG_SECONDS = 8'h20;
    localparam logic [7:0] RTC_REG_MINUTES = 8'h21;
    localparam logic [7:0] RTC_REG_HOURS   = 8'h22;
    localparam logic [7:0] RTC_REG_DATE    = 8'h23;
    localparam logic [7:0] RTC_REG_MONTH   = 8'h24;
    localparam logic [7:0] RTC_REG_YEAR    = 8'h25;
    localparam logic [7:0] RTC_REG_CHRONO  = 8'h26;

    // Returns 1 when the read path wins arbitration. A lone request always
    // wins; when both paths request, the one not served last time wins, so a
    // continuously requesting write path cannot starve the refresh path.
    function automatic logic arb_pick_read(input logic wr_req,
                                           input logic rd_req,
                                           input logic last_wr);
        return rd_req && (!wr_req || last_wr);
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_phase_timer.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter_phase_timer
//   Phase counter for the RTC bus cycle. Counts 0 .. T_PHASE-1 while enabled
//   and returns to 0 after the terminal count, so each bus phase lasts exactly
//   T_PHASE clocks. A load forces the count back to 0 (start of a new cycle).
//
// Ports
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   load_i  in   restart the count at 0 on the next edge
//   en_i    in   advance the count (bus cycle in progress)
//   tc_o    out  count is at T_PHASE-1 (last cycle of the current phase)
// ---------------------------------------------------------------------------
module rtc_bus_arbiter_phase_timer #(
    parameter int unsigned T_PHASE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    // T_PHASE >= 2 is the legal range; the guard keeps the width sane anyway.
    localparam int unsigned CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_PHASE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // The count never passes LAST: the terminal cycle reloads 0 instead of
    // incrementing, which matters for non power-of-two phase lengths.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
//   Shares the multiplexed address/data RTC bus between the write path
//   (hour/date/chrono programming) and the periodic read-refresh path.
//   Arbitrates in IDLE, then sequences one single-register bus cycle per
//   grant: ADDR, ADDR_HOLD, DATA, RECOVER, each T_PHASE clocks long.
//   Grant appears in cycle 0, done pulses in cycle 4*T_PHASE.
//
// Request/grant handshake: a request is a level held by the requester until
//   its grant pulse (one cycle). Address/data/direction are captured on the
//   same edge that raises the grant, so the requester may change its inputs
//   from the grant cycle onward. Requests are only looked at in IDLE; a
//   request dropped before it is granted is forgotten. done pulses for one
//   cycle at the end of the transaction and done_rd tells whether it was a
//   read; rd_data holds the last value read from done onward.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_req_i/wr_addr_i/wr_data_i   write request, register address, data
//   rd_req_i/rd_addr_i      read request, register address
//   wr_grant_o/rd_grant_o   one-cycle grant pulses
//   busy_o                  transaction in progress (grant .. before done)
//   done_o/done_rd_o        completion pulse and its read qualifier
//   rd_data_o               last read value
//   bus_cs_n_o, bus_ad_o, bus_wr_n_o, bus_rd_n_o   RTC bus control pins
//   ad_out_o/ad_oe_o/ad_in_i  multiplexed AD bus drive, enable and sample
//   state_o                 current bus-cycle state (debug)
//
// ADDR_W and DATA_W must be equal: both share the one AD bus.
// ---------------------------------------------------------------------------
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int unsigned T_PHASE = DEF_T_PHASE,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              wr_grant_o,
    output logic              rd_grant_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              done_rd_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              bus_cs_n_o,
    output logic              bus_ad_o,
    output logic              bus_wr_n_o,
    output logic              bus_rd_n_o,
    output logic [ADDR_W-1:0] ad_out_o,
    output logic              ad_oe_o,
    input  logic [DATA_W-1:0] ad_in_i,
    output state_e            state_o
);

    state_e            state_q,    state_d;
    logic              last_wr_q,  last_wr_d;
    logic              dir_rd_q,   dir_rd_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              wr_grant_q, wr_grant_d;
    logic              rd_grant_q, rd_grant_d;
    logic              done_q,     done_d;
    logic              done_rd_q,  done_rd_d;

    logic              start;
    logic              pick_rd;
    logic              phase_end;

    // ------------------------------------------------------------------
    // Phase timer: restarted on every grant, runs whenever a cycle is on.
    // ------------------------------------------------------------------
    rtc_bus_arbiter_phase_timer #(
        .T_PHASE (T_PHASE)
    ) u_phase_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (start),
        .en_i   (state_q != ST_IDLE),
        .tc_o   (phase_end)
    );

    // ------------------------------------------------------------------
    // Arbitration and next-state logic
    // ------------------------------------------------------------------
    assign start   = (state_q == ST_IDLE) && (wr_req_i || rd_req_i);
    assign pick_rd = arb_pick_read(wr_req_i, rd_req_i, last_wr_q);

    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        dir_rd_d   = dir_rd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        wr_grant_d = 1'b0;
        rd_grant_d = 1'b0;
        done_d     = 1'b0;
        done_rd_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_rd_d   = pick_rd;
                    last_wr_d  = !pick_rd;
                    addr_d     = pick_rd ? rd_addr_i : wr_addr_i;
                    data_d     = wr_data_i;
                    wr_grant_d = !pick_rd;
                    rd_grant_d = pick_rd;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (phase_end) state_d = ST_ADDR_HOLD;
            end
            ST_ADDR_HOLD: begin
                if (phase_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (phase_end) begin
                    state_d = ST_RECOVER;
                    // Sample as late as possible to give the RTC the full
                    // DATA phase to drive the bus.
                    if (dir_rd_q) rd_data_d = ad_in_i;
                end
            end
            ST_RECOVER: begin
                if (phase_end) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    done_rd_d = dir_rd_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_wr_q  <= 1'b0;
            dir_rd_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            done_q     <= 1'b0;
            done_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            dir_rd_q   <= dir_rd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            done_q     <= done_d;
            done_rd_q  <= done_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus pin decode: purely a function of the registered state, so pins
    // change only on clock edges. Idle level: deselected, all strobes
    // high, AD bus released and driven value parked at zero.
    // ------------------------------------------------------------------
    always_comb begin
        bus_cs_n_o = 1'b1;
        bus_ad_o   = 1'b0;
        bus_wr_n_o = 1'b1;
        bus_rd_n_o = 1'b1;
        ad_oe_o    = 1'b0;
        ad_out_o   = '0;

        unique case (state_q)
            ST_ADDR: begin
                // wr_n low here is the RTC's address latch strobe.
                bus_cs_n_o = 1'b0;
                bus_wr_n_o = 1'b0;
                ad_oe_o    = 1'b1;
                ad_out_o   = addr_q;
            end
            ST_ADDR_HOLD: begin
                bus_cs_n_o = 1'b0;
                ad_oe_o    = 1'b1;
                ad_out_o   = addr_q;
            end
            ST_DATA: begin
                bus_cs_n_o = 1'b0;
                bus_ad_o   = 1'b1;
                if (dir_rd_q) begin
                    bus_rd_n_o = 1'b0;
                end else begin
                    bus_wr_n_o = 1'b0;
                    ad_oe_o    = 1'b1;
                    ad_out_o   = ADDR_W'(data_q);
                end
            end
            default: begin
                // IDLE and RECOVER keep the idle levels.
            end
        endcase
    end

    assign wr_grant_o = wr_grant_q;
    assign rd_grant_o = rd_grant_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign done_rd_o  = done_rd_q;
    assign rd_data_o  = rd_data_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
module tb_rtc_bus_arbiter;
    import rtc_bus_arbiter_pkg::*;

    localparam int T   = 8;
    localparam int TXN = 4 * T;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req, rd_req;
    logic [7:0] wr_addr, wr_data, rd_addr, ad_in;
    logic       wr_grant, rd_grant, busy, done, done_rd;
    logic [7:0] rd_data, ad_out;
    logic       bus_cs_n, bus_ad, bus_wr_n, bus_rd_n, ad_oe;
    state_e     state;

    always #5 clk = ~clk;

    rtc_bus_arbiter #(.T_PHASE(T), .ADDR_W(8), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_req_i   (wr_req),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .wr_grant_o (wr_grant),
        .rd_grant_o (rd_grant),
        .busy_o     (busy),
        .done_o     (done),
        .done_rd_o  (done_rd),
        .rd_data_o  (rd_data),
        .bus_cs_n_o (bus_cs_n),
        .bus_ad_o   (bus_ad),
        .bus_wr_n_o (bus_wr_n),
        .bus_rd_n_o (bus_rd_n),
        .ad_out_o   (ad_out),
        .ad_oe_o    (ad_oe),
        .ad_in_i    (ad_in),
        .state_o    (state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction is an offset 0 .. 4*T-1 from its grant cycle; bus pins
    // follow from offset / T. Offset 4*T is the done cycle (model idle).
    bit         m_active = 0;
    int         m_off    = 0;
    bit         m_rd     = 0;
    bit         m_last_wr = 0;
    logic [7:0] m_addr = '0, m_data = '0, m_rd_data = '0;
    bit         m_wg = 0, m_rg = 0, m_done = 0, m_done_rd = 0;

    always @(posedge clk) begin
        m_wg = 0; m_rg = 0; m_done = 0; m_done_rd = 0;
        if (rst) begin
            m_active = 0; m_off = 0; m_last_wr = 0; m_rd_data = '0;
        end else if (m_active) begin
            if (m_rd && m_off == 3 * T - 1) m_rd_data = ad_in;
            if (m_off == TXN - 1) begin
                m_active = 0; m_done = 1; m_done_rd = m_rd;
            end else begin
                m_off++;
            end
        end else if (wr_req || rd_req) begin
            if (wr_req && rd_req) m_rd = m_last_wr;   // alternate on contention
            else                  m_rd = rd_req;
            m_last_wr = !m_rd;
            m_addr = m_rd ? rd_addr : wr_addr;
            m_data = wr_data;
            m_active = 1; m_off = 0;
            if (m_rd) m_rg = 1; else m_wg = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         cmp_en = 0;
    int         e_ph;
    bit         e_cs_n, e_ad, e_wr_n, e_rd_n, e_oe, e_ad_care;
    logic [7:0] e_out;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_cs_n = 1; e_ad = 0; e_wr_n = 1; e_rd_n = 1; e_oe = 0; e_out = '0; e_ad_care = 1;
            e_ph = m_active ? (m_off / T) : -1;
            if (e_ph == 0 || e_ph == 1) begin
                e_cs_n = 0; e_oe = 1; e_out = m_addr; e_wr_n = (e_ph == 1);
            end else if (e_ph == 2) begin
                e_cs_n = 0; e_ad = 1;
                if (m_rd) e_rd_n = 0;
                else begin e_wr_n = 0; e_oe = 1; e_out = m_data; end
            end else if (e_ph == 3) begin
                e_ad_care = 0;
            end
            check("m_wr_grant", wr_grant, m_wg);
            check("m_rd_grant", rd_grant, m_rg);
            check("m_busy", busy, m_active);
            check("m_done", done, m_done);
            check("m_done_rd", done_rd, m_done_rd);
            check("m_rd_data", rd_data, m_rd_data);
            check("m_cs_n", bus_cs_n, e_cs_n);
            check("m_wr_n", bus_wr_n, e_wr_n);
            check("m_rd_n", bus_rd_n, e_rd_n);
            check("m_ad_oe", ad_oe, e_oe);
            if (e_ad_care) check("m_bus_ad", bus_ad, e_ad);
            if (e_oe || !m_active) check("m_ad_out", ad_out, e_out);
            if (!m_active) check("m_state_idle", state, ST_IDLE);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (wr_grant === 1'b1 || rd_grant === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    logic [0:0] exp_q[$];
    bit         gdir[$];
    int         gcyc[$];
    bit         ok;
    int         n_done, n_rd;

    initial begin
        rst = 1; wr_req = 0; rd_req = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; ad_in = '0;
        @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        check("rst_cs_n", bus_cs_n, 1);
        check("rst_wr_n", bus_wr_n, 1);
        check("rst_rd_n", bus_rd_n, 1);
        check("rst_ad", bus_ad, 0);
        check("rst_oe", ad_oe, 0);
        check("rst_ad_out", ad_out, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_state", state, ST_IDLE);
        @(negedge clk);
        rst = 0;

        // Write, with inputs changed after grant (latched values must stay).
        wr_addr = 8'h21; wr_data = 8'h45; wr_req = 1;
        wait_grant(ok);
        wr_req = 0;
        check("t1_wr_grant_c0", wr_grant, 1);
        check("t1_ad_out_c0", ad_out, 8'h21);
        check("t1_wr_n_c0", bus_wr_n, 0);
        for (int k = 1; k <= TXN; k++) begin
            @(negedge clk);
            if (k == 1) begin wr_addr = 8'hA5; wr_data = 8'h5A; end
            if (k == 7)  check("t1_wr_n_c7", bus_wr_n, 0);
            if (k == 8)  check("t1_wr_n_c8", bus_wr_n, 1);
            if (k == 15) check("t5_ad_out_c15_latched", ad_out, 8'h21);
            if (k == 16) begin
                check("t5_ad_out_c16_latched", ad_out, 8'h45);
                check("t1_bus_ad_c16", bus_ad, 1);
            end
            if (k == 23) check("t1_wr_n_c23", bus_wr_n, 0);
            if (k == 31) check("t1_done_c31", done, 0);
            if (k == TXN) begin
                check("t1_done_c32", done, 1);
                check("t1_done_rd_c32", done_rd, 0);
                check("t1_busy_c32", busy, 0);
            end
        end

        // Read with the RTC driving 59 during DATA.
        rd_addr = 8'h22; rd_req = 1;
        wait_grant(ok);
        rd_req = 0;
        check("t2_rd_grant_c0", rd_grant, 1);
        check("t2_ad_out_c0", ad_out, 8'h22);
        for (int k = 1; k <= TXN; k++) begin
            @(negedge clk);
            if (k == 16) begin
                ad_in = 8'h59;
                check("t2_rd_n_c16", bus_rd_n, 0);
                check("t2_oe_c16", ad_oe, 0);
            end
            if (k == 23) check("t2_rd_n_c23", bus_rd_n, 0);
            if (k == 24) begin
                ad_in = 8'h00;
                check("t2_rd_n_c24", bus_rd_n, 1);
            end
            if (k == TXN) begin
                check("t2_rd_data_c32", rd_data, 8'h59);
                check("t2_done_c32", done, 1);
                check("t2_done_rd_c32", done_rd, 1);
            end
        end

        // Contention from reset: write, read, write, read, 33 cycles apart.
        rst = 1; wr_req = 1; rd_req = 1;
        wr_addr = RTC_REG_MONTH; wr_data = 8'h07; rd_addr = RTC_REG_YEAR; ad_in = 8'h3C;
        @(negedge clk); @(negedge clk);
        rst = 0;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4 * 33 + 20; i++) begin
            @(negedge clk);
            if (wr_grant === 1'b1 || rd_grant === 1'b1) begin
                gdir.push_back(rd_grant === 1'b1);
                gcyc.push_back(i);
            end
            if (gdir.size() == 4) break;
        end
        wr_req = 0; rd_req = 0;
        check("t3_grant_count", gdir.size(), 4);
        for (int i = 0; i < gdir.size(); i++) begin
            check("t3_grant_order", gdir[i], exp_q.pop_front());
            if (i > 0) check("t3_grant_spacing", gcyc[i] - gcyc[i-1], 33);
        end
        wait_done();

        // Reset during cycle 20 of a read.
        rd_addr = RTC_REG_CHRONO; rd_req = 1;
        wait_grant(ok);
        rd_req = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 19) check("t4_rd_data_before", rd_data, 8'h3C);
            if (k == 20) rst = 1;
            if (k == 21) begin
                check("t4_cs_n_c21", bus_cs_n, 1);
                check("t4_rd_n_c21", bus_rd_n, 1);
                check("t4_busy_c21", busy, 0);
                check("t4_rd_data_c21", rd_data, 0);
                check("t4_state_c21", state, ST_IDLE);
                rst = 0;
            end
        end
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("t4_no_done", n_done, 0);

        // Reset mid-write clears the round-robin memory: write wins again.
        wr_addr = RTC_REG_HOURS; wr_data = 8'h12; wr_req = 1;
        wait_grant(ok);
        wr_req = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; wr_req = 1; rd_req = 1;
        wait_grant(ok);
        check("t4b_wr_first_after_reset", wr_grant, 1);
        wr_req = 0; rd_req = 0;
        wait_done();

        // Read request pulsed while busy and dropped before done.
        wr_addr = RTC_REG_DATE; wr_data = 8'h31; wr_req = 1;
        wait_grant(ok);
        wr_req = 0;
        n_rd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5)  rd_req = 1;
            if (k == 10) rd_req = 0;
            if (rd_grant === 1'b1) n_rd++;
        end
        check("t6_no_rd_grant", n_rd, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
